// File: rtl/id_ex_stage.sv
// id_ex_stage: instruction decode and ID/EX pipeline register with load-use
// stall sequencing, downstream hold and early branch resolution.
module id_ex_stage #(
  parameter int XLEN     = 32,
  parameter int LOAD_LAT = 1,
  parameter bit BNE_EN   = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            ex_hold,
  output logic            pc_load,
  output logic            if_id_load,
  output logic            if_id_flush,
  output logic            branch_taken,
  output logic [XLEN-1:0] branch_target,
  output logic            ex_valid,
  output logic            ex_mem_re,
  output logic            ex_mem_we,
  output logic            ex_reg_write,
  output logic            ex_branch,
  output logic [1:0]      ex_alu_op,
  output logic [4:0]      ex_rd,
  output logic [9:0]      ex_funct,
  output logic [XLEN-1:0] ex_rs1,
  output logic [XLEN-1:0] ex_rs2,
  output logic [XLEN-1:0] ex_imm,
  output logic [XLEN-1:0] ex_pc
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [1:0] STALL_INIT = 2'(LOAD_LAT - 1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_LSTALL = 2'd1,
    ST_HOLD   = 2'd2
  } stageState_t;

  stageState_t r_state;
  stageState_t r_savedState;
  logic [1:0]  r_stallCnt;

  logic            r_exValid, r_exMemRe, r_exMemWe, r_exRegWrite, r_exBranch;
  logic [1:0]      r_exAluOp;
  logic [4:0]      r_exRd;
  logic [9:0]      r_exFunct;
  logic [XLEN-1:0] r_exRs1, r_exRs2, r_exImm, r_exPc;

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [4:0]      w_rs1Idx, w_rs2Idx, w_rdIdx;
  logic [XLEN-1:0] w_immI, w_immS, w_immB;
  logic            w_decValid, w_decMemRe, w_decMemWe, w_decRegWrite, w_decBranch;
  logic            w_usesRs2;
  logic [1:0]      w_decAluOp;
  logic [XLEN-1:0] w_decImm;
  logic            w_hazard, w_issue, w_brCond;
  stageState_t     w_resumeState;

  assign w_opcode = instruction[6:0];
  assign w_funct3 = instruction[14:12];
  assign w_rs1Idx = instruction[19:15];
  assign w_rs2Idx = instruction[24:20];
  assign w_rdIdx  = instruction[11:7];
  assign w_immI   = {{(XLEN-12){instruction[31]}}, instruction[31:20]};
  assign w_immS   = {{(XLEN-12){instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign w_immB   = {{(XLEN-13){instruction[31]}}, instruction[31], instruction[7],
                     instruction[30:25], instruction[11:8], 1'b0};

  // Opcode decode into control bits; anything unrecognised or not valid is a bubble
  always_comb begin
    w_decValid    = 1'b0;
    w_decMemRe    = 1'b0;
    w_decMemWe    = 1'b0;
    w_decRegWrite = 1'b0;
    w_decBranch   = 1'b0;
    w_decAluOp    = 2'b00;
    w_decImm      = '0;
    w_usesRs2     = 1'b0;
    case (w_opcode)
      OP_R: begin
        w_decValid = 1'b1; w_decRegWrite = 1'b1; w_decAluOp = 2'b10; w_usesRs2 = 1'b1;
      end
      OP_IALU: begin
        w_decValid = 1'b1; w_decRegWrite = 1'b1; w_decAluOp = 2'b10; w_decImm = w_immI;
      end
      OP_LOAD: begin
        w_decValid = 1'b1; w_decMemRe = 1'b1; w_decRegWrite = 1'b1; w_decImm = w_immI;
      end
      OP_STORE: begin
        w_decValid = 1'b1; w_decMemWe = 1'b1; w_decImm = w_immS; w_usesRs2 = 1'b1;
      end
      OP_BRANCH: begin
        w_decValid = 1'b1; w_decBranch = 1'b1; w_decAluOp = 2'b01; w_decImm = w_immB;
        w_usesRs2 = 1'b1;
      end
      default: ;
    endcase
    if (!in_valid) begin
      w_decValid    = 1'b0;
      w_decMemRe    = 1'b0;
      w_decMemWe    = 1'b0;
      w_decRegWrite = 1'b0;
      w_decBranch   = 1'b0;
      w_decAluOp    = 2'b00;
      w_decImm      = '0;
    end
  end

  // Branch condition from the register-file operands
  always_comb begin
    w_brCond = 1'b0;
    case (w_funct3)
      3'b000:  w_brCond = (rs1_data == rs2_data);
      3'b001:  w_brCond = BNE_EN && (rs1_data != rs2_data);
      default: w_brCond = 1'b0;
    endcase
  end

  // A load in EX whose destination feeds this instruction forces a bubble
  assign w_hazard = r_exValid & r_exMemRe & (r_exRd != 5'd0) &
                    ((r_exRd == w_rs1Idx) | ((r_exRd == w_rs2Idx) & w_usesRs2)) & in_valid;

  // Leaving HOLD behaves as the state that was interrupted, in the same cycle
  assign w_resumeState = (r_state == ST_HOLD) ? r_savedState : r_state;
  assign w_issue       = ~ex_hold & (w_resumeState == ST_RUN) & ~w_hazard;

  assign pc_load       = reset & w_issue;
  assign if_id_load    = reset & w_issue;
  assign branch_taken  = reset & w_issue & w_decBranch & w_brCond;
  assign if_id_flush   = branch_taken;
  assign branch_target = reset ? (pc_in + w_decImm) : '0;

  // Stall sequencer: hold freezes everything, load-use counts down bubbles
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_RUN;
      r_savedState <= ST_RUN;
      r_stallCnt   <= 2'd0;
    end else if (ex_hold) begin
      if (r_state != ST_HOLD) r_savedState <= r_state;
      r_state <= ST_HOLD;
    end else if (w_resumeState == ST_LSTALL) begin
      r_stallCnt <= (r_stallCnt != 2'd0) ? (r_stallCnt - 2'd1) : 2'd0;
      r_state    <= (r_stallCnt <= 2'd1) ? ST_RUN : ST_LSTALL;
    end else if (w_hazard) begin
      r_stallCnt <= STALL_INIT;
      r_state    <= (LOAD_LAT > 1) ? ST_LSTALL : ST_RUN;
    end else begin
      r_state <= ST_RUN;
    end
  end

  // ID/EX register: frozen on hold, decoded word on issue, otherwise a bubble
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_exValid <= 1'b0; r_exMemRe <= 1'b0; r_exMemWe <= 1'b0;
      r_exRegWrite <= 1'b0; r_exBranch <= 1'b0; r_exAluOp <= 2'b00;
      r_exRd <= 5'd0; r_exFunct <= 10'd0;
      r_exRs1 <= '0; r_exRs2 <= '0; r_exImm <= '0; r_exPc <= '0;
    end else if (!ex_hold) begin
      r_exValid    <= w_issue & w_decValid;
      r_exMemRe    <= w_issue & w_decMemRe;
      r_exMemWe    <= w_issue & w_decMemWe;
      r_exRegWrite <= w_issue & w_decRegWrite;
      r_exBranch   <= w_issue & w_decBranch;
      r_exAluOp    <= (w_issue & w_decValid) ? w_decAluOp : 2'b00;
      r_exRd       <= (w_issue & w_decValid) ? w_rdIdx : 5'd0;
      r_exFunct    <= (w_issue & w_decValid) ? {instruction[31:25], w_funct3} : 10'd0;
      r_exRs1      <= (w_issue & w_decValid) ? rs1_data : '0;
      r_exRs2      <= (w_issue & w_decValid) ? rs2_data : '0;
      r_exImm      <= (w_issue & w_decValid) ? w_decImm : '0;
      r_exPc       <= (w_issue & w_decValid) ? pc_in : '0;
    end
  end

  assign ex_valid     = r_exValid;
  assign ex_mem_re    = r_exMemRe;
  assign ex_mem_we    = r_exMemWe;
  assign ex_reg_write = r_exRegWrite;
  assign ex_branch    = r_exBranch;
  assign ex_alu_op    = r_exAluOp;
  assign ex_rd        = r_exRd;
  assign ex_funct     = r_exFunct;
  assign ex_rs1       = r_exRs1;
  assign ex_rs2       = r_exRs2;
  assign ex_imm       = r_exImm;
  assign ex_pc        = r_exPc;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width (legal 32 or 64).
REQ-002 Parameter LOAD_LAT, default 1, load-use stall cycles (legal 1..3).
REQ-003 Parameter BNE_EN, default 1, enables BNE resolution in decode.
REQ-004 The block SHALL have one clock; reset SHALL be asynchronous and active-low; ports named clock and reset.
REQ-005 clock  in  1  rising-edge clock.
REQ-006 reset  in  1  async active-low reset.
REQ-007 in_valid  in  1  IF/ID holds a real instruction.
REQ-008 instruction  in  32  IF/ID instruction word.
REQ-009 pc_in  in  XLEN  IF/ID PC.
REQ-010 rs1_data, rs2_data  in  XLEN each  register-file read data for instruction[19:15], instruction[24:20].
REQ-011 ex_hold  in  1  downstream back-pressure; freeze stage.
REQ-012 pc_load, if_id_load  out  1 each  front-end advance enables.
REQ-013 if_id_flush  out  1  squash IF/ID contents next edge.
REQ-014 branch_taken  out  1; branch_target  out  XLEN.
REQ-015 ex_valid, ex_mem_re, ex_mem_we, ex_reg_write, ex_branch  out  1 each; ex_alu_op  out  2; ex_rd  out  5; ex_funct  out  10 ({funct7,funct3}); ex_rs1, ex_rs2, ex_imm, ex_pc  out  XLEN.

Function
REQ-016 Decode: 0110011 R (reg_write, alu_op 10); 0010011 I-ALU (reg_write, alu_op 10, imm); 0000011 load (mem_re, reg_write, alu_op 00); 0100011 store (mem_we, alu_op 00); 1100011 SB (branch, alu_op 01); any other opcode or in_valid=0 SHALL decode as bubble.
REQ-017 Immediate: I-type sign-extended [31:20]; S {[31:25],[11:7]}; SB {[31],[7],[30:25],[11:8],0}; sign-extended to XLEN; R-type imm = 0.
REQ-018 FSM states RUN, LSTALL, HOLD; 2-bit counter stall_cnt.
REQ-019 Load-use hazard = ex_valid & ex_mem_re & ex_rd!=0 & (ex_rd==rs1 | (ex_rd==rs2 & opcode in {R,S,SB})) & in_valid.
REQ-020 RUN, no hazard, ex_hold=0: ID/EX loads decoded instruction on next edge; pc_load=if_id_load=1.
REQ-021 RUN, hazard: ID/EX loads bubble; pc_load=if_id_load=0; stall_cnt<=LOAD_LAT-1; go LSTALL if LOAD_LAT>1, else remain RUN (hazard clears since ID/EX now bubble).
REQ-022 LSTALL: bubble inserted each cycle, pc_load=if_id_load=0, stall_cnt decrements; at stall_cnt==0 -> RUN.
REQ-023 ex_hold=1 in any state: go/stay HOLD; ID/EX, stall_cnt frozen; pc_load=if_id_load=0; branch_taken=0; on ex_hold=0 return to saved state (RUN or LSTALL).
REQ-024 Bubble: ex_valid, all control bits, ex_rd SHALL be 0; data fields don't-care.
REQ-025 Branch in RUN without hazard: BEQ (funct3 000) taken iff rs1_data==rs2_data; BNE (001, BNE_EN=1) taken iff unequal; other funct3 not taken.
REQ-026 branch_taken combinational, same cycle; branch_target=pc_in+imm modulo 2^XLEN; if_id_flush=branch_taken; branch still enters ID/EX with ex_branch=1.
REQ-027 Branch with load-use hazard: branch_taken SHALL be 0 until hazard clears.
REQ-028 Priority: reset > ex_hold > load-use stall > branch.
REQ-029 Latency: decode to ID/EX outputs 1 cycle.

Reset
REQ-030 reset=0 SHALL immediately force state RUN, stall_cnt 0, all ex_* outputs 0, pc_load=if_id_load=if_id_flush=branch_taken=0, branch_target 0.
REQ-031 Reset mid-LSTALL or mid-HOLD SHALL abandon stall; first edge after release is RUN.

Verification
REQ-032 add x3,x1,x2 (0x002081B3), in_valid=1 -> next cycle ex_valid=1, ex_rd=3, ex_reg_write=1, ex_alu_op=10, ex_funct=0.
REQ-033 lw x5,0(x1) then add x6,x5,x2, LOAD_LAT=1 -> one bubble (ex_valid=0), pc_load=0 one cycle, add issued following cycle.
REQ-034 Same sequence with LOAD_LAT=3 -> exactly 3 bubbles, pc_load low 3 cycles.
REQ-035 beq x1,x2,+16 at pc 0x100, rs1=rs2=7 -> branch_taken=1, branch_target=0x110, if_id_flush=1; rs1=7, rs2=8 -> taken=0.
REQ-036 ex_hold=1 for 2 cycles during LSTALL -> ID/EX and stall_cnt unchanged, stall resumes after release with remaining count.
REQ-037 reset low during LSTALL -> all outputs 0 immediately, RUN after release, no residual bubble.
